rob_queue: RTL



---
 rtl/rob_pkg.sv | 38 +++
 rtl/rob_queue_ptr.sv | 38 +++
 rtl/rob_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Purpose  : Shared types for the reorder buffer. Commit-director codes,
//            ROB control states and the per-slot status record.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

  // Commit director carried by each booking; codes 2/3 are reserved.
  typedef enum logic [1:0] {
    DIREC_NORMAL      = 2'd0,
    DIREC_FLUSH_AFTER = 2'd1
  } commit_direc_e;

  // ROB control state.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  // Per-slot status. The register payload (areg/preg) sits in separate
  // arrays so its width can follow the module parameters.
  typedef struct packed {
    logic          busy;
    logic          done;
    logic          exc;
    logic          wr;
    commit_direc_e direc;
  } rob_entry_t;

  // Map the raw 2-bit director code; reserved codes behave as NORMAL.
  function automatic commit_direc_e decode_direc(input logic [1:0] code);
    return (code == 2'd1) ? DIREC_FLUSH_AFTER : DIREC_NORMAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rob_ptr
// Purpose  : Circular ROB pointer with a wrap bit above the slot index.
//            Supports increment and a synchronous clear to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rob_ptr
  import rob_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W:0]   o_ptr
);

  localparam logic [W:0] c_ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] r_ptr;

  // Pointer register: clear has priority, otherwise wrap naturally at 2*2^W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + c_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rob_queue.sv
`default_nettype none
// ============================================================================
// Module   : rob_queue
// Purpose  : In-order reorder buffer. Books one entry per cycle, marks
//            entries done from completion broadcasts, retires one entry per
//            cycle in program order and raises a one-cycle flush on an
//            exception or after a FLUSH_AFTER entry retires.
// Revision : 1.0 - initial release
// ============================================================================
module rob_queue
  import rob_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int AREG_W  = 5,
  parameter int PREG_W  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_alloc_valid,
  output logic                        o_alloc_ready,
  input  logic                        i_alloc_wr,
  input  logic [AREG_W-1:0]           i_alloc_areg,
  input  logic [PREG_W-1:0]           i_alloc_preg,
  input  logic [1:0]                  i_alloc_direc,
  output logic [$clog2(ENTRIES)-1:0]  o_alloc_tag,
  input  logic                        i_cpl_valid,
  input  logic [$clog2(ENTRIES)-1:0]  i_cpl_tag,
  input  logic                        i_cpl_exc,
  output logic                        o_commit_valid,
  output logic                        o_commit_wr,
  output logic [AREG_W-1:0]           o_commit_areg,
  output logic [PREG_W-1:0]           o_commit_preg,
  output logic                        o_flush,
  output logic                        o_empty,
  output logic                        o_full
);

  localparam int TAG_W = $clog2(ENTRIES);

  rob_entry_t        r_slot [ENTRIES];
  logic [AREG_W-1:0] r_areg [ENTRIES];
  logic [PREG_W-1:0] r_preg [ENTRIES];

  rob_state_e        r_state;
  rob_state_e        w_state_nxt;
  logic              r_pend;          // FLUSH_AFTER retired; flush next cycle

  logic              r_commit_valid;
  logic              r_commit_wr;
  logic [AREG_W-1:0] r_commit_areg;
  logic [PREG_W-1:0] r_commit_preg;

  logic [TAG_W:0]    w_head;
  logic [TAG_W:0]    w_tail;
  logic [TAG_W-1:0]  w_hidx;
  logic [TAG_W-1:0]  w_tidx;
  rob_entry_t        w_hslot;
  logic              w_full;
  logic              w_run;
  logic              w_alloc;
  logic              w_clr;
  logic              w_cpl_hit;
  logic              w_cpl_head;
  logic              w_h_done;
  logic              w_h_exc;
  logic              w_commit;
  logic              w_except;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_commit),
    .i_clr (w_clr),
    .o_ptr (w_head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_alloc),
    .i_clr (w_clr),
    .o_ptr (w_tail)
  );

  assign w_hidx  = w_head[TAG_W-1:0];
  assign w_tidx  = w_tail[TAG_W-1:0];
  assign w_hslot = r_slot[w_hidx];
  assign w_full  = (w_hidx == w_tidx) && (w_head[TAG_W] != w_tail[TAG_W]);
  assign w_clr   = (r_state == ST_FLUSH);

  // Bookings and retirement are only live in RUN with no flush pending.
  assign w_run   = (r_state == ST_RUN) && !r_pend;
  assign w_alloc = i_alloc_valid && o_alloc_ready;

  // A completion landing on the head this cycle is forwarded so the head
  // can retire on the very next cycle. If the head is already done, its
  // stored status wins and the late completion is ignored.
  assign w_cpl_hit  = i_cpl_valid && (r_state == ST_RUN) && r_slot[i_cpl_tag].busy;
  assign w_cpl_head = w_cpl_hit && (i_cpl_tag == w_hidx);
  assign w_h_done   = w_hslot.done || w_cpl_head;
  assign w_h_exc    = w_hslot.done ? w_hslot.exc : i_cpl_exc;
  assign w_commit   = w_run && w_hslot.busy && w_h_done && !w_h_exc;
  assign w_except   = w_run && w_hslot.busy && w_h_done && w_h_exc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: an exception or a pending FLUSH_AFTER enters FLUSH for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_except || r_pend) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Remember that a FLUSH_AFTER entry just retired; its flush follows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (w_clr) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_commit && (w_hslot.direc == DIREC_FLUSH_AFTER);
    end
  end

  // Slot status: flush wipes everything; otherwise complete, retire, book.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_slot[i] <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < ENTRIES; i++) r_slot[i] <= '0;
    end else begin
      if (w_cpl_hit) begin
        r_slot[i_cpl_tag].done <= 1'b1;
        r_slot[i_cpl_tag].exc  <= i_cpl_exc;
      end
      if (w_commit) begin
        r_slot[w_hidx].busy <= 1'b0;
      end
      if (w_alloc) begin
        r_slot[w_tidx] <= '{busy: 1'b1, done: 1'b0, exc: 1'b0,
                           wr: i_alloc_wr, direc: decode_direc(i_alloc_direc)};
      end
    end
  end

  // Register payload; only meaningful while the slot is busy, so no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_areg[w_tidx] <= i_alloc_areg;
      r_preg[w_tidx] <= i_alloc_preg;
    end
  end

  // Registered retirement broadcast; fields are zero when nothing retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_valid <= 1'b0;
      r_commit_wr    <= 1'b0;
      r_commit_areg  <= '0;
      r_commit_preg  <= '0;
    end else begin
      r_commit_valid <= w_commit;
      r_commit_wr    <= w_commit && w_hslot.wr;
      r_commit_areg  <= w_commit ? r_areg[w_hidx] : '0;
      r_commit_preg  <= w_commit ? r_preg[w_hidx] : '0;
    end
  end

  assign o_alloc_ready  = w_run && !w_full;
  assign o_alloc_tag    = w_tidx;
  assign o_empty        = (w_head == w_tail);
  assign o_full         = w_full;
  assign o_flush        = (r_state == ST_FLUSH);
  assign o_commit_valid = r_commit_valid;
  assign o_commit_wr    = r_commit_wr;
  assign o_commit_areg  = r_commit_areg;
  assign o_commit_preg  = r_commit_preg;

endmodule
`default_nettype wire
